// File: rtl/sme_host_seq.sv
// sme_host_seq: host-side sequencer for the string-matching engine (SME).
// Software fills a string buffer (32 bytes) and a pattern buffer (8 bytes),
// then pulses start. The block streams the string (optional) and the pattern
// with isstring/ispattern framing, waits for the engine's sme_valid (bounded
// by TIMEOUT cycles) and presents the outcome on a ready/valid result port.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   cfg_we/sel/addr/data buffer write port (ignored while busy)
//   str_len, pat_len     lengths, clamped to 32 / 8 and latched at start
//   send_str             1 = string then pattern, 0 = pattern only
//   start                single-cycle request, accepted in IDLE with pat_len!=0
//   busy                 high from the cycle after start through the handshake
//   chardata/isstring/ispattern  character stream to the SME
//   sme_valid/sme_match/sme_match_index  engine result
//   res_valid/res_ready  result handshake
//   res_match/res_index/res_timeout  captured result
module sme_host_seq #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_we,
   input  logic       cfg_sel,
   input  logic [4:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic [5:0] str_len,
   input  logic [3:0] pat_len,
   input  logic       send_str,
   input  logic       start,
   output logic       busy,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   input  logic       sme_match,
   input  logic [4:0] sme_match_index,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       res_timeout
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SEND_STR = 3'd1;
   localparam logic [2:0] S_SEND_PAT = 3'd2;
   localparam logic [2:0] S_WAIT     = 3'd3;
   localparam logic [2:0] S_RESULT   = 3'd4;

   localparam logic [5:0] STR_CLAMP = 6'(STR_MAX);
   localparam logic [3:0] PAT_CLAMP = 4'(PAT_MAX);
   // Last WAIT cycle index (counter starts at 0 on the first WAIT cycle).
   localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

   logic [7:0] str_mem [STR_MAX];
   logic [7:0] pat_mem [PAT_MAX];

   logic [2:0] state;
   logic [5:0] idx;     // index of the next character to present
   logic [5:0] str_l;
   logic [3:0] pat_l;
   logic [9:0] wcnt;

   // Buffers are not reset; writes are blocked while a transaction runs.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy) begin
         if (cfg_sel) pat_mem[cfg_addr[2:0]] <= cfg_data;
         else         str_mem[cfg_addr]      <= cfg_data;
      end
   end

   // Outputs are registered and loaded one cycle ahead: the state names the
   // character currently on chardata, idx the one to load at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         str_l       <= '0;
         pat_l       <= '0;
         wcnt        <= '0;
         busy        <= 1'b0;
         chardata    <= '0;
         isstring    <= 1'b0;
         ispattern   <= 1'b0;
         res_valid   <= 1'b0;
         res_match   <= 1'b0;
         res_index   <= '0;
         res_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && pat_len != '0) begin
                  busy  <= 1'b1;
                  str_l <= (str_len > STR_CLAMP) ? STR_CLAMP : str_len;
                  pat_l <= (pat_len > PAT_CLAMP) ? PAT_CLAMP : pat_len;
                  idx   <= 6'd1;
                  if (send_str && str_len != '0) begin
                     state    <= S_SEND_STR;
                     chardata <= str_mem[5'd0];
                     isstring <= 1'b1;
                  end else begin
                     state     <= S_SEND_PAT;
                     chardata  <= pat_mem[3'd0];
                     ispattern <= 1'b1;
                  end
               end
            end
            S_SEND_STR: begin
               if (idx == str_l) begin
                  state     <= S_SEND_PAT;
                  chardata  <= pat_mem[3'd0];
                  isstring  <= 1'b0;
                  ispattern <= 1'b1;
                  idx       <= 6'd1;
               end else begin
                  chardata <= str_mem[idx[4:0]];
                  idx      <= idx + 6'd1;
               end
            end
            S_SEND_PAT: begin
               if (idx == {2'b00, pat_l}) begin
                  state     <= S_WAIT;
                  chardata  <= '0;
                  ispattern <= 1'b0;
                  wcnt      <= '0;
               end else begin
                  chardata <= pat_mem[idx[2:0]];
                  idx      <= idx + 6'd1;
               end
            end
            S_WAIT: begin
               // sme_valid is checked first so it wins on the final cycle.
               if (sme_valid) begin
                  state       <= S_RESULT;
                  res_valid   <= 1'b1;
                  res_match   <= sme_match;
                  res_index   <= sme_match ? sme_match_index : 5'd0;
                  res_timeout <= 1'b0;
               end else if (wcnt == WAIT_LAST) begin
                  state       <= S_RESULT;
                  res_valid   <= 1'b1;
                  res_match   <= 1'b0;
                  res_index   <= '0;
                  res_timeout <= 1'b1;
               end else begin
                  wcnt <= wcnt + 10'd1;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  state     <= S_IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sme_host_seq.sv
// Testbench for sme_host_seq: randomized transactions compared against a
// transaction-level model (expected character stream built from buffer
// images, expected result latency and fields from the SME response plan).
module tb_sme_host_seq;

   localparam int TIMEOUT = 1023;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we, cfg_sel;
   logic [4:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [5:0] str_len;
   logic [3:0] pat_len;
   logic       send_str, start, busy;
   logic [7:0] chardata;
   logic       isstring, ispattern;
   logic       sme_valid, sme_match;
   logic [4:0] sme_match_index;
   logic       res_valid, res_ready, res_match, res_timeout;
   logic [4:0] res_index;

   always #5 clk = ~clk;

   sme_host_seq #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .str_len(str_len), .pat_len(pat_len), .send_str(send_str), .start(start),
      .busy(busy), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
      .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
      .res_index(res_index), .res_timeout(res_timeout)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] smem [32];
   logic [7:0] pmem [8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {busy, isstring, ispattern, chardata, res_valid, res_match,
                  res_index, res_timeout}, 32'd0);
   endtask

   // Called at a negedge while idle; returns one negedge later.
   task automatic wr(input bit sel, input int addr, input logic [7:0] d);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 5'(addr); cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
      if (sel) pmem[addr % 8] = d;
      else     smem[addr % 32] = d;
   endtask

   task automatic load_str(input bit sel, input string s);
      for (int i = 0; i < s.len(); i++) wr(sel, i, 8'(s[i]));
   endtask

   // One full transaction. d: WAIT cycle index (0 = first) on which the SME
   // model raises valid; never: SME stays silent. rst_at >= 0 aborts with a
   // reset while character rst_at is on the bus.
   task automatic run_txn(input int slen, input int plen, input bit sendstr,
                          input bit never, input int d, input bit m,
                          input logic [4:0] mi, input int hold,
                          input bit wr_at_start, input int rst_at);
      int L = sendstr ? ((slen > 32) ? 32 : slen) : 0;
      int P = (plen > 8) ? 8 : plen;
      logic [7:0] eq[$];
      bit es[$];
      int cnt;
      for (int i = 0; i < L; i++) begin eq.push_back(smem[i]); es.push_back(1'b1); end
      for (int i = 0; i < P; i++) begin eq.push_back(pmem[i]); es.push_back(1'b0); end

      check("idle_before_start", busy, 1'b0);
      str_len = 6'(slen); pat_len = 4'(plen); send_str = sendstr; start = 1'b1;
      if (wr_at_start) begin
         cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_data = ~smem[0];
      end
      @(negedge clk);
      start = 1'b0;
      if (wr_at_start) begin cfg_we = 1'b0; smem[0] = cfg_data; end

      if (P == 0) begin
         check("ignored_start_busy", busy, 1'b0);
         check("ignored_start_frame", {isstring, ispattern}, 2'b00);
         @(negedge clk);
         check("ignored_start_busy2", busy, 1'b0);
         return;
      end

      for (int k = 0; k < eq.size(); k++) begin
         if (k == rst_at) begin
            #2 reset = 1'b0;
            #1 check_all_zero("async_reset_outs");
            @(negedge clk);
            reset = 1'b1; cfg_we = 1'b0; sme_valid = 1'b0;
            @(negedge clk);
            check_all_zero("after_reset_outs");
            return;
         end
         check("busy_send", busy, 1'b1);
         check("isstring", isstring, es[k]);
         check("ispattern", ispattern, !es[k]);
         check("chardata", chardata, eq[k]);
         // Noise that must be ignored: writes while busy, valid outside WAIT.
         cfg_we = 1'($urandom_range(0, 1)); cfg_sel = 1'($urandom_range(0, 1));
         cfg_addr = 5'($urandom); cfg_data = 8'($urandom);
         sme_valid = 1'($urandom_range(0, 1));
         sme_match = 1'($urandom_range(0, 1)); sme_match_index = 5'($urandom);
         @(negedge clk);
      end
      cfg_we = 1'b0; sme_valid = 1'b0;
      check("wait_entry_frame", {isstring, ispattern, chardata}, 10'd0);
      check("wait_busy", busy, 1'b1);

      cnt = 0;
      while (res_valid !== 1'b1 && cnt < 2000) begin
         if (!never && cnt == d) begin
            sme_valid = 1'b1; sme_match = m; sme_match_index = mi;
         end else begin
            sme_valid = 1'b0;
            sme_match = 1'($urandom_range(0, 1)); sme_match_index = 5'($urandom);
         end
         @(negedge clk);
         cnt++;
      end
      sme_valid = 1'b0;
      check("result_latency", cnt, never ? TIMEOUT : d + 1);
      check("res_valid", res_valid, 1'b1);
      check("res_match", res_match, never ? 1'b0 : m);
      check("res_index", res_index, (never || !m) ? 5'd0 : mi);
      check("res_timeout", res_timeout, never);

      for (int h = 0; h < hold; h++) begin
         res_ready = 1'b0;
         start = (h == hold / 2);
         pat_len = 4'd1;
         sme_valid = 1'($urandom_range(0, 1)); sme_match = 1'($urandom_range(0, 1));
         sme_match_index = 5'($urandom);
         @(negedge clk);
         start = 1'b0;
         check("hold_valid", res_valid, 1'b1);
         check("hold_fields", {res_match, res_index, res_timeout},
               {never ? 1'b0 : m, (never || !m) ? 5'd0 : mi, never});
         check("hold_busy", busy, 1'b1);
         check("hold_frame", {isstring, ispattern}, 2'b00);
      end
      sme_valid = 1'b0;
      res_ready = 1'b1;
      start = 1'($urandom_range(0, 1));   // start on the handshake cycle is ignored
      pat_len = 4'd3;
      @(negedge clk);
      res_ready = 1'b0; start = 1'b0;
      check("post_hs_valid", res_valid, 1'b0);
      check("post_hs_busy", busy, 1'b0);
      @(negedge clk);
      check("post_hs_idle", {busy, isstring, ispattern}, 3'b000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
      str_len = '0; pat_len = '0; send_str = 1'b0; start = 1'b0;
      sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0; res_ready = 1'b0;
      @(negedge clk);
      check_all_zero("reset_outs");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset_idle");

      for (int i = 0; i < 32; i++) wr(1'b0, i, 8'($urandom));
      for (int i = 0; i < 8; i++)  wr(1'b1, i, 8'($urandom));

      // "abcde" / "cd" -> match at 2.
      load_str(1'b0, "abcde");
      load_str(1'b1, "cd");
      run_txn(5, 2, 1'b1, 1'b0, 3, 1'b1, 5'd2, 2, 1'b0, -1);
      // Pattern only, no match; index must be forced to 0.
      load_str(1'b1, "xy");
      run_txn(5, 2, 1'b0, 1'b0, 0, 1'b0, 5'd7, 1, 1'b0, -1);
      // Silent SME -> timeout, then a long res_ready hold with a start pulse.
      run_txn(5, 2, 1'b1, 1'b1, 0, 1'b0, 5'd0, 20, 1'b0, -1);
      // Valid on the last possible WAIT cycle wins over timeout.
      run_txn(3, 1, 1'b1, 1'b0, TIMEOUT - 1, 1'b1, 5'd9, 0, 1'b0, -1);
      // Edge lengths and clamping.
      for (int i = 0; i < 32; i++) wr(1'b0, i, 8'($urandom));
      for (int i = 0; i < 8; i++)  wr(1'b1, i, 8'($urandom));
      run_txn(32, 8, 1'b1, 1'b0, 5, 1'b1, 5'd31, 0, 1'b0, -1);
      run_txn(40, 8, 1'b1, 1'b0, 1, 1'b0, 5'd4, 0, 1'b0, -1);
      run_txn(63, 15, 1'b1, 1'b0, 2, 1'b1, 5'd17, 0, 1'b0, -1);
      run_txn(0, 3, 1'b1, 1'b0, 0, 1'b1, 5'd0, 0, 1'b0, -1);
      run_txn(8, 0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 0, 1'b0, -1);
      // Write coinciding with start: old byte sent, new byte used next time.
      run_txn(4, 2, 1'b1, 1'b0, 0, 1'b1, 5'd1, 0, 1'b1, -1);
      run_txn(4, 2, 1'b1, 1'b0, 0, 1'b1, 5'd1, 0, 1'b0, -1);
      // Reset during the string phase, then a normal transaction.
      run_txn(10, 3, 1'b1, 1'b0, 0, 1'b0, 5'd0, 0, 1'b0, 4);
      run_txn(10, 3, 1'b1, 1'b0, 2, 1'b1, 5'd6, 1, 1'b0, -1);

      for (int t = 0; t < 25; t++) begin
         int nw = $urandom_range(0, 6);
         for (int w = 0; w < nw; w++) begin
            if ($urandom_range(0, 1) == 1) wr(1'b1, $urandom_range(0, 7), 8'($urandom));
            else                            wr(1'b0, $urandom_range(0, 31), 8'($urandom));
         end
         run_txn($urandom_range(0, 63), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 20),
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 5),
                 1'b0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
